// File: rtl/booth_mul_seq_pkg.sv
// Shared datapath constants, FSM state encoding and Booth step encoding
// for the sequential multiplier and its adder.
package booth_mul_seq_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_m1}.
  function automatic booth_op_t booth_sel(input logic q0, input logic q_m1);
    booth_op_t op;
    case ({q0, q_m1})
      2'b10:   op = OP_SUB;
      2'b01:   op = OP_ADD;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mul_seq_add_op.sv
// Ripple carry-chain adder: sum = a + b + cin, carry-out dropped.
// Purely combinational.
module add_op #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per cycle,
// signed 2*WIDTH product in hi_out/lo_out, start/busy/done handshake.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A_reg,
  input  logic [WIDTH-1:0] B_reg,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [CNT_W-1:0] cnt;

  booth_op_t        op;
  logic [WIDTH:0]   add_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sum;

  // Subtraction is ACC + ~M + 1, so the adder only ever sees M or ~M.
  always_comb begin
    op    = booth_sel(q[0], q_m1);
    add_b = (op == OP_SUB) ? ~m : m;
  end

  add_op #(
    .WIDTH (WIDTH + 1)
  ) u_add (
    .a   (acc),
    .b   (add_b),
    .cin (op == OP_SUB),
    .sum (add_sum)
  );

  always_comb begin
    sum = (op == OP_NONE) ? acc : add_sum;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      m      <= '0;
      acc    <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m     <= {A_reg[WIDTH-1], A_reg};
            q     <= B_reg;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          acc  <= {sum[WIDTH], sum[WIDTH:1]};
          q    <= {sum[0], q[WIDTH-1:1]};
          q_m1 <= q[0];
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            // Post-shift {ACC[W-1:0], Q} is exactly {sum[W:0], Q[W-1:1]}.
            {hi_out, lo_out} <= {sum[WIDTH:0], q[WIDTH-1:1]};
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq against a plain signed-multiply model.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_cmp = 0;
  int n_bad = 0;

  booth_mul_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (start),
    .A_reg  (a_in),
    .B_reg  (b_in),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  // Pulse start for one edge; returns at the negedge right after the sampling edge.
  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts sampling edge as cycle 1; stops at the negedge where done is seen.
  task automatic wait_done(output int cycles, output bit timed_out);
    cycles    = 1;
    timed_out = 1'b0;
    while (!done) begin
      if (cycles >= 100) begin
        timed_out = 1'b1;
        return;
      end
      @(negedge clk);
      a_in = $urandom;
      b_in = $urandom;
      cycles++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    clr_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, hi_out, lo_out} !== 66'd0) begin
        n_bad++;
        $display("FAIL reset_idle: got busy=%b done=%b hi=%h lo=%h expected all zero",
                 busy, done, hi_out, lo_out);
      end
    end
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, hi_out, lo_out} !== 66'd0) begin
        n_bad++;
        $display("FAIL idle_after_reset: got busy=%b done=%b hi=%h lo=%h expected all zero",
                 busy, done, hi_out, lo_out);
      end
    end
  endtask

  task automatic test_product(input string name, input logic [31:0] a, input logic [31:0] b);
    int          cycles;
    bit          to;
    logic [63:0] exp;
    exp = ref_mul(a, b);
    pulse_start(a, b);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_busy: got %b expected 1", name, busy);
    end
    wait_done(cycles, to);
    n_cmp++;
    if (to || cycles != 33) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d cycles (timeout=%0d) expected 33", name, cycles, to);
    end
    n_cmp++;
    if ({hi_out, lo_out} !== exp || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_result: got %h_%h busy=%b expected %h_%h busy=0",
               name, hi_out, lo_out, busy, exp[63:32], exp[31:0]);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || {hi_out, lo_out} !== exp) begin
      n_bad++;
      $display("FAIL %s_hold: got done=%b %h_%h expected done=0 %h_%h",
               name, done, hi_out, lo_out, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_basic;
    test_product("seven_by_m3", 32'd7, 32'hFFFFFFFD);
    n_cmp++;
    if ({hi_out, lo_out} !== 64'hFFFFFFFF_FFFFFFEB) begin
      n_bad++;
      $display("FAIL seven_by_m3_const: got %h_%h expected ffffffff_ffffffeb", hi_out, lo_out);
    end
  endtask

  task automatic test_edges;
    test_product("min_by_min", 32'h80000000, 32'h80000000);
    test_product("min_by_m1", 32'h80000000, 32'hFFFFFFFF);
    test_product("m1_by_m1", 32'hFFFFFFFF, 32'hFFFFFFFF);
    test_product("max_by_min", 32'h7FFFFFFF, 32'h80000000);
    test_product("zero_by_x", 32'd0, 32'hDEADBEEF);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      test_product("random", $urandom, $urandom);
    end
  endtask

  task automatic test_ignore_start;
    int          cycles;
    int          pulses;
    int          done_at;
    logic [63:0] exp;
    exp     = ref_mul(32'd5, 32'd6);
    pulse_start(32'd5, 32'd6);
    cycles  = 1;
    pulses  = 0;
    done_at = 0;
    while (cycles < 45) begin
      if (done) begin
        pulses++;
        if (done_at == 0) done_at = cycles;
      end
      @(negedge clk);
      cycles++;
      start = (cycles == 10);
      a_in  = 32'd100;
      b_in  = 32'd200;
    end
    start = 1'b0;
    n_cmp++;
    if (pulses != 1 || done_at != 33) begin
      n_bad++;
      $display("FAIL ignore_start_done: got %0d pulses first at %0d expected 1 at 33",
               pulses, done_at);
    end
    n_cmp++;
    if ({hi_out, lo_out} !== exp) begin
      n_bad++;
      $display("FAIL ignore_start_result: got %h_%h expected %h_%h",
               hi_out, lo_out, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_back_to_back;
    int          cycles;
    bit          to;
    logic [63:0] exp1;
    logic [63:0] exp2;
    exp1 = ref_mul(32'd11, 32'd13);
    exp2 = ref_mul(32'hFFFFFFFC, 32'd9);
    pulse_start(32'd11, 32'd13);
    for (int i = 1; i < 32; i++) @(negedge clk);
    a_in  = 32'hFFFFFFFC;
    b_in  = 32'd9;
    start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || {hi_out, lo_out} !== exp1) begin
      n_bad++;
      $display("FAIL b2b_first: got done=%b %h_%h expected done=1 %h_%h",
               done, hi_out, lo_out, exp1[63:32], exp1[31:0]);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || {hi_out, lo_out} !== exp1) begin
      n_bad++;
      $display("FAIL b2b_restart: got busy=%b done=%b %h_%h expected busy=1 done=0 %h_%h",
               busy, done, hi_out, lo_out, exp1[63:32], exp1[31:0]);
    end
    wait_done(cycles, to);
    n_cmp++;
    if (to || cycles != 33 || {hi_out, lo_out} !== exp2) begin
      n_bad++;
      $display("FAIL b2b_second: got %0d cycles %h_%h expected 33 %h_%h",
               cycles, hi_out, lo_out, exp2[63:32], exp2[31:0]);
    end
    n_cmp++;
    if ({hi_out, lo_out} !== 64'hFFFFFFFF_FFFFFFDC) begin
      n_bad++;
      $display("FAIL b2b_second_const: got %h_%h expected ffffffff_ffffffdc", hi_out, lo_out);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int pulses;
    pulse_start(32'h12345678, 32'h9ABCDEF0);
    for (int i = 1; i < 15; i++) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, hi_out, lo_out} !== 66'd0) begin
      n_bad++;
      $display("FAIL abort_async: got busy=%b done=%b hi=%h lo=%h expected all zero",
               busy, done, hi_out, lo_out);
    end
    @(negedge clk);
    clr_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || {hi_out, lo_out} !== 64'd0) begin
      n_bad++;
      $display("FAIL abort_quiet: got %0d busy/done cycles out=%h_%h expected 0 and zero",
               pulses, hi_out, lo_out);
    end
    test_product("after_abort", 32'hFFFF0001, 32'd12345);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
